// File: rtl/fma_norm_shift.sv
// fma_norm_shift
//   Normalization shifter for the fused multiply-add datapath. It takes the
//   unnormalized sum magnitude, the leading-zero anticipator's shift count
//   (exact or one short) and a preliminary exponent. It produces a
//   normalized mantissa and exponent through two pipeline stages:
//     S1: coarse shift by the anticipated count, exponent adjusted to match.
//     S2: one-bit correction when the anticipator came up one short.
//   Both stages use a valid/ready handshake. Throughput is one result per
//   cycle, and a result appears two cycles after it is presented when the
//   output is not stalled.
//
// Ports
//   clk       clock, all state updates on the rising edge
//   reset     synchronous active-high reset
//   InValid   upstream presents a valid sum
//   InReady   block accepts the sum this cycle
//   Sm        unnormalized sum magnitude, MSB-aligned (WIDTH bits)
//   SCnt      anticipated shift count, exact or one short
//   Se        preliminary exponent, signed (NE+2 bits)
//   OutValid  normalized result valid
//   OutReady  downstream accepts the result
//   Mf        normalized mantissa, MSB set unless ZeroOut
//   Me        normalized exponent (wraps modulo 2^(NE+2))
//   ZeroOut   the sum was exactly zero
//   LzaErr    a leading zero remains after correction (anticipator miss)
module fma_norm_shift #(
  parameter int WIDTH = 16,
  parameter int NE    = 8,
  localparam int CW   = $clog2(WIDTH+1),
  localparam int EW   = NE + 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] Sm,
  input  logic [CW-1:0]    SCnt,
  input  logic [EW-1:0]    Se,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Mf,
  output logic [EW-1:0]    Me,
  output logic             ZeroOut,
  output logic             LzaErr
);

  logic             s1Valid;
  logic [WIDTH-1:0] s1Sh;
  logic [EW-1:0]    s1Ex;
  logic             s1Z;

  logic             s2Valid;

  logic             s1Advance;
  logic             s2Advance;
  logic             inXfer;
  logic             s1Move;

  logic             s2Corr;
  logic [WIDTH-1:0] s2MfNext;
  logic [EW-1:0]    s2MeNext;
  logic             s2LzaNext;

  // Handshake. A stage can take new data when it is empty or when its
  // contents leave this cycle. S1 therefore sees S2's advance, so a full
  // pipeline with OutReady high keeps streaming without a bubble. InReady is
  // masked by reset so nothing is accepted on the edge that clears the pipe.
  always_comb begin
    s2Advance = ~s2Valid | OutReady;
    s1Advance = ~s1Valid | s2Advance;
    InReady   = s1Advance & ~reset;
    inXfer    = InValid & InReady;
    s1Move    = s1Valid & s1Advance;
  end

  // Stage 1: coarse shift by the anticipated count. Shifting by WIDTH or
  // more shifts every bit out, which gives zero. The count is unsigned, so it
  // is zero-extended before the exponent subtraction. The data registers only
  // load on an input transfer. Otherwise they hold, so a stalled S1 keeps its
  // operand.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1Valid <= 1'b0;
      s1Sh    <= '0;
      s1Ex    <= '0;
      s1Z     <= 1'b0;
    end else begin
      s1Valid <= inXfer | (s1Valid & ~s1Advance);
      if (inXfer) begin
        s1Sh <= Sm << SCnt;
        s1Ex <= Se - EW'(SCnt);
        s1Z  <= (Sm == '0);
      end
    end
  end

  // Stage 2 combinational correction. The anticipator is at most one short.
  // If the top bit is still clear after the coarse shift, shift once more and
  // take one more off the exponent. A zero sum overrides everything and
  // produces a clean all-zero result. LzaErr flags a leading zero that remains
  // after correction. That result is passed through as-is.
  always_comb begin
    s2Corr    = ~s1Sh[WIDTH-1] & ~s1Z;
    s2MfNext  = s2Corr ? (s1Sh << 1) : s1Sh;
    s2MeNext  = s1Ex - EW'(s2Corr);
    if (s1Z) begin
      s2MfNext = '0;
      s2MeNext = '0;
    end
    s2LzaNext = ~s1Z & ~s2MfNext[WIDTH-1];
  end

  // Stage 2 output registers. These load only when S1 moves forward, so a
  // stalled result (OutValid high, OutReady low) stays exactly where it is
  // until the downstream takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2Valid <= 1'b0;
      Mf      <= '0;
      Me      <= '0;
      ZeroOut <= 1'b0;
      LzaErr  <= 1'b0;
    end else begin
      s2Valid <= s1Move | (s2Valid & ~OutReady);
      if (s1Move) begin
        Mf      <= s2MfNext;
        Me      <= s2MeNext;
        ZeroOut <= s1Z;
        LzaErr  <= s2LzaNext;
      end
    end
  end

  assign OutValid = s2Valid;

endmodule
